// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// bit-counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = a - b - borrow_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock,
// with a start/busy/done handshake and registered results.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bff;
    logic             borrow_msb_in;
    logic             d_bit;
    logic             b_next;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (bff),
        .diff       (d_bit),
        .borrow_out (b_next)
    );

    assign res_next = {d_bit, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            diff          <= '0;
            borrow_out    <= 1'b0;
            overflow      <= 1'b0;
            cnt           <= '0;
            bff           <= 1'b0;
            borrow_msb_in <= 1'b0;
            a_sr          <= '0;
            b_sr          <= '0;
            res_sr        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bff   <= borrow_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    bff    <= b_next;
                    // Borrow leaving bit WIDTH-2 is the borrow entering the MSB.
                    if (cnt == CNT_PRE_LAST) begin
                        borrow_msb_in <= b_next;
                    end
                    if (cnt == CNT_LAST) begin
                        // Results land together with the done pulse.
                        diff       <= res_next;
                        borrow_out <= b_next;
                        overflow   <= borrow_msb_in ^ b_next;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results are
// queued at launch and checked by a monitor on every done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
        exp_t       e;
        logic [W:0] f;
        int         s;
        f    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
        s    = int'($signed(x)) - int'($signed(y)) - int'(bin);
        e.d  = f[W-1:0];
        e.bo = f[W];
        e.ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("borrow_out", 32'(borrow_out), 32'(e.bo));
                chk("overflow", 32'(overflow), 32'(e.ov));
            end
        end
    end

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin, input exp_t e);
        @(negedge clk);
        a         = x;
        b         = y;
        borrow_in = bin;
        start     = 1'b1;
        sb.push_back(e);
    endtask

    // Drops start after the accepting edge and counts cycles until done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                          input logic [W-1:0] ed, input logic ebo, input logic eov);
        exp_t e;
        int   lat;
        int   bcnt;
        e.d  = ed;
        e.bo = ebo;
        e.ov = eov;
        launch(x, y, bin, e);
        wait_done(lat, bcnt);
        chk("latency", 32'(lat), 32'(W + 1));
        chk("busy_cycles", 32'(bcnt), 32'(W + 1));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   lat;
        int   bcnt;
        int   dcnt;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic bin;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bo", 32'(borrow_out), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        rst = 1'b0;

        run_op(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, 1'b0);
        run_op(8'd37, 8'd100, 1'b0, 8'hC1, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op(8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            x   = W'($urandom);
            y   = W'($urandom);
            bin = 1'($urandom);
            e   = model(x, y, bin);
            run_op(x, y, bin, e.d, e.bo, e.ov);
        end

        // Busy-time starts and operand changes must not disturb the operation.
        run_op(8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);
        e.d = 8'h3F; e.bo = 1'b0; e.ov = 1'b0;
        launch(8'd100, 8'd37, 1'b0, e);
        dcnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            a     = W'($urandom);
            b     = W'($urandom);
            borrow_in = 1'($urandom);
            start = (i == 3 || i == 9);
            if (i == 3) begin a = 8'd1; b = 8'd2; end
            if (i == 5) chk("diff_hold", 32'(diff), 32'd7);
            if (done === 1'b1) begin
                dcnt++;
                chk("ignore_latency", 32'(i), 32'(W + 1));
            end
            if (i == 10) chk("idle_after_ignored", 32'(busy), 32'd0);
        end
        start = 1'b0;
        chk("ignore_done_count", 32'(dcnt), 32'd1);

        // Reset during RUN aborts with cleared outputs and no done pulse.
        e.d = 8'h3F; e.bo = 1'b0; e.ov = 1'b0;
        launch(8'd100, 8'd37, 1'b0, e);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bo", 32'(borrow_out), 32'd0);
        chk("abort_ov", 32'(overflow), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        run_op(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, 1'b0);

        // Start held high launches back-to-back every WIDTH+2 cycles.
        e = model(8'd200, 8'd55, 1'b1);
        launch(8'd200, 8'd55, 1'b1, e);
        sb.push_back(e);
        dcnt = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 20) start = 1'b0;
            if (done === 1'b1) begin
                dcnt++;
                chk("b2b_done_at", 32'(i), 32'(dcnt == 1 ? W + 1 : 2 * W + 3));
            end
        end
        chk("b2b_done_count", 32'(dcnt), 32'd2);
        chk("queue_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
